// File: rtl/code_sequencer.sv
// code_sequencer: program sequencer feeding the training controller.
// Holds the op-code program memory and runs a loaded program for a requested
// number of epochs. It presents op/code_count/code_index to the controller and
// reacts to the controller's code_reset/code_active/count_reset strobes.
// Optional watchdog: define CODE_SEQ_WDOG_EN to build it. When the macro is
// undefined, wdog_err is tied low and code_count simply saturates.
module code_sequencer #(
   parameter int OP_SIZE    = 4,
   parameter int ADDR_W     = 4,
   parameter int WDOG_LIMIT = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [31:0]         epoch_count,
   input  logic [ADDR_W:0]     prog_len,
   input  logic                prog_we,
   input  logic [ADDR_W-1:0]   prog_addr,
   input  logic [OP_SIZE-1:0]  prog_op,
   input  logic                count_reset,
   input  logic                code_reset,
   input  logic                code_active,
   output logic [OP_SIZE-1:0]  op,
   output logic [31:0]         code_count,
   output logic [31:0]         code_index,
   output logic                enable,
   output logic                busy,
   output logic                done,
   output logic [31:0]         epochs_left,
   output logic                wdog_err
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

`ifdef CODE_SEQ_WDOG_EN
   localparam bit WDOG_BUILD = 1'b1;
`else
   localparam bit WDOG_BUILD = 1'b0;
`endif
   // Last code_count value tolerated before the watchdog trips.
   localparam logic [31:0] WDOG_LAST = 32'(WDOG_LIMIT - 1);

   logic [OP_SIZE-1:0] mem_q [DEPTH];

   logic [1:0]         state_q, state_d;
   logic [OP_SIZE-1:0] op_q, op_d;
   logic [31:0]        count_q, count_d;
   logic [ADDR_W-1:0]  index_q, index_d;
   logic [ADDR_W:0]    len_q, len_d;
   logic [31:0]        epochs_q, epochs_d;
   logic               enable_q;
   logic               busy_q;
   logic               done_q, done_d;
   logic               start_go;
   logic               wdog_trip;
   logic [ADDR_W-1:0]  idx_inc;
   logic               last_line;

   // Saturating cycle counter increment.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Program memory: written only while no program is running; never reset.
   always_ff @(posedge clk) begin
      if (prog_we && (state_q != S_RUN)) begin
         mem_q[prog_addr] <= prog_op;
      end
   end

   // Next-state logic: start handling and strobe priority while running.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      count_d   = count_q;
      index_d   = index_q;
      len_d     = len_q;
      epochs_d  = epochs_q;
      done_d    = done_q;
      start_go  = 1'b0;
      wdog_trip = 1'b0;
      idx_inc   = index_q + 1'b1;
      // An index that overruns the memory depth wraps naturally to 0.
      last_line = ({1'b0, index_q} == (len_q - 1'b1));

      case (state_q)
         S_RUN: begin
            if (code_reset) begin
               index_d  = '0;
               count_d  = '0;
               op_d     = mem_q[0];
               epochs_d = epochs_q - 32'd1;
               if (epochs_q == 32'd1) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  op_d    = '0;
               end
            end else if (code_active) begin
               count_d = '0;
               if (last_line) begin
                  index_d = '0;
                  op_d    = mem_q[0];
               end else begin
                  index_d = idx_inc;
                  op_d    = mem_q[idx_inc];
               end
            end else if (count_reset) begin
               count_d = '0;
            end else if (WDOG_BUILD && (count_q == WDOG_LAST)) begin
               wdog_trip = 1'b1;
               state_d   = S_DONE;
               done_d    = 1'b1;
               op_d      = '0;
            end else begin
               count_d = sat_inc(count_q);
            end
         end
         default: begin
            if (start) begin
               start_go = 1'b1;
               index_d  = '0;
               count_d  = '0;
               if ((epoch_count == 32'd0) || (prog_len == '0)) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  epochs_d = '0;
                  op_d     = '0;
               end else begin
                  state_d  = S_RUN;
                  done_d   = 1'b0;
                  epochs_d = epoch_count;
                  len_d    = prog_len;
                  op_d     = mem_q[0];
               end
            end
         end
      endcase
   end

   // Control and output registers; enable/busy track the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         count_q  <= '0;
         index_q  <= '0;
         len_q    <= '0;
         epochs_q <= '0;
         enable_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         count_q  <= count_d;
         index_q  <= index_d;
         len_q    <= len_d;
         epochs_q <= epochs_d;
         enable_q <= (state_d == S_RUN);
         busy_q   <= (state_d == S_RUN);
         done_q   <= done_d;
      end
   end

`ifdef CODE_SEQ_WDOG_EN
   logic wdog_q;

   // Watchdog flag: set on a trip, cleared by the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_q <= 1'b0;
      end else if (start_go) begin
         wdog_q <= 1'b0;
      end else if (wdog_trip) begin
         wdog_q <= 1'b1;
      end
   end

   assign wdog_err = wdog_q;
`else
   logic unused_wdog;
   assign unused_wdog = start_go ^ wdog_trip;
   assign wdog_err    = 1'b0;
`endif

   assign op          = op_q;
   assign code_count  = count_q;
   assign code_index  = {{(32-ADDR_W){1'b0}}, index_q};
   assign enable      = enable_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign epochs_left = epochs_q;

endmodule

// File: tb/tb_code_sequencer.sv
// Scoreboard bench for code_sequencer: the stimulus process queues expected
// output values tagged with the cycle they apply to; a monitor process on the
// falling edge pops and compares them.
module tb_code_sequencer;

   localparam int OP_SIZE = 4;
   localparam int ADDR_W  = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [31:0]         epoch_count;
   logic [ADDR_W:0]     prog_len;
   logic                prog_we;
   logic [ADDR_W-1:0]   prog_addr;
   logic [OP_SIZE-1:0]  prog_op;
   logic                count_reset;
   logic                code_reset;
   logic                code_active;
   logic [OP_SIZE-1:0]  op;
   logic [31:0]         code_count;
   logic [31:0]         code_index;
   logic                enable;
   logic                busy;
   logic                done;
   logic [31:0]         epochs_left;
   logic                wdog_err;

   code_sequencer #(.OP_SIZE(OP_SIZE), .ADDR_W(ADDR_W), .WDOG_LIMIT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .epoch_count(epoch_count),
      .prog_len(prog_len), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_op(prog_op), .count_reset(count_reset), .code_reset(code_reset),
      .code_active(code_active), .op(op), .code_count(code_count),
      .code_index(code_index), .enable(enable), .busy(busy), .done(done),
      .epochs_left(epochs_left), .wdog_err(wdog_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   localparam int S_OP = 0, S_CNT = 1, S_IDX = 2, S_EN = 3, S_BUSY = 4,
                  S_DONE = 5, S_EP = 6, S_WD = 7;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] dut_val(input int sel);
      case (sel)
         S_OP:    return 32'(op);
         S_CNT:   return code_count;
         S_IDX:   return code_index;
         S_EN:    return 32'(enable);
         S_BUSY:  return 32'(busy);
         S_DONE:  return 32'(done);
         S_EP:    return epochs_left;
         default: return 32'(wdog_err);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare every queued expectation due at this cycle.
   always @(negedge clk) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc == cyc) begin
            chk(q[i].name, dut_val(q[i].sel), q[i].val);
            q.delete(i);
         end
      end
   end

   // Queue an expectation for the state just latched by the latest edge.
   task automatic expect_now(input int sel, input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc = cyc; e.sel = sel; e.val = v; e.name = nm;
      q.push_back(e);
   endtask

   task automatic expect_all(input logic [31:0] o, input logic [31:0] c,
                             input logic [31:0] ix, input logic en,
                             input logic dn, input logic [31:0] ep, input string tag);
      expect_now(S_OP,   o,  {tag, ".op"});
      expect_now(S_CNT,  c,  {tag, ".code_count"});
      expect_now(S_IDX,  ix, {tag, ".code_index"});
      expect_now(S_EN,   32'(en), {tag, ".enable"});
      expect_now(S_BUSY, 32'(en), {tag, ".busy"});
      expect_now(S_DONE, 32'(dn), {tag, ".done"});
      expect_now(S_EP,   ep, {tag, ".epochs_left"});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mem(input int a, input int d);
      prog_we = 1'b1; prog_addr = ADDR_W'(a); prog_op = OP_SIZE'(d);
      step();
      prog_we = 1'b0;
   endtask

   task automatic do_start(input int ep, input int len);
      epoch_count = 32'(ep); prog_len = (ADDR_W+1)'(len); start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".op"},          32'(op),      32'd0);
      chk({tag, ".code_count"},  code_count,   32'd0);
      chk({tag, ".code_index"},  code_index,   32'd0);
      chk({tag, ".enable"},      32'(enable),  32'd0);
      chk({tag, ".busy"},        32'(busy),    32'd0);
      chk({tag, ".done"},        32'(done),    32'd0);
      chk({tag, ".epochs_left"}, epochs_left,  32'd0);
      chk({tag, ".wdog_err"},    32'(wdog_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; epoch_count = '0; prog_len = '0;
      prog_we = 1'b0; prog_addr = '0; prog_op = '0;
      count_reset = 1'b0; code_reset = 1'b0; code_active = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      write_mem(0, 1);
      write_mem(1, 2);

      // Run: 3 epochs, 2-line program, no strobes for 5 cycles.
      do_start(3, 2);
      expect_all(1, 0, 0, 1, 0, 3, "start");
      for (int k = 1; k <= 5; k++) begin
         step();
         expect_now(S_CNT, 32'(k), "count_up");
         expect_now(S_OP, 32'd1, "count_up.op");
      end

      code_active = 1'b1; step(); code_active = 1'b0;
      expect_all(2, 0, 1, 1, 0, 3, "active");
      step();
      expect_now(S_CNT, 32'd1, "line1_count");

      code_reset = 1'b1; step(); code_reset = 1'b0;
      expect_all(1, 0, 0, 1, 0, 2, "epoch1");

      code_reset = 1'b1; code_active = 1'b1; step();
      code_reset = 1'b0; code_active = 1'b0;
      expect_all(1, 0, 0, 1, 0, 1, "prio");

      step(); step();
      expect_now(S_CNT, 32'd2, "pre_count_reset");
      count_reset = 1'b1; step(); count_reset = 1'b0;
      expect_now(S_CNT, 32'd0, "count_reset.count");
      expect_now(S_IDX, 32'd0, "count_reset.index");

      code_active = 1'b1; step();
      expect_all(2, 0, 1, 1, 0, 1, "adv");
      step(); code_active = 1'b0;
      expect_all(1, 0, 0, 1, 0, 1, "wrap");

      code_reset = 1'b1; step(); code_reset = 1'b0;
      expect_all(0, 0, 0, 0, 1, 0, "done");

      code_reset = 1'b1; code_active = 1'b1; count_reset = 1'b1;
      step(); step();
      code_reset = 1'b0; code_active = 1'b0; count_reset = 1'b0;
      expect_all(0, 0, 0, 0, 1, 0, "done_hold");

      // Program writes during RUN are ignored.
      do_start(1, 2);
      expect_all(1, 0, 0, 1, 0, 1, "runB");
      prog_we = 1'b1; prog_addr = '0; prog_op = 4'd7;
      step(); prog_we = 1'b0;
      expect_now(S_OP, 32'd1, "we_in_run.op");
      code_reset = 1'b1; step(); code_reset = 1'b0;
      expect_now(S_DONE, 32'd1, "runB_done");
      do_start(2, 2);
      expect_all(1, 0, 0, 1, 0, 2, "mem_kept");

      // Asynchronous reset in the middle of a cycle.
      step(); step();
      #2 rst = 1'b1;
      #1;
      check_zero("async_rst");
      step();
      rst = 1'b0;
      step();

      do_start(1, 2);
      expect_all(1, 0, 0, 1, 0, 1, "restart");
      code_active = 1'b1; step(); code_active = 1'b0;
      expect_now(S_OP, 32'd2, "restart_line1.op");
      code_reset = 1'b1; step(); code_reset = 1'b0;
      expect_now(S_DONE, 32'd1, "restart_done");

      // Degenerate starts go straight to DONE.
      do_start(0, 2);
      expect_all(0, 0, 0, 0, 1, 0, "zero_epochs");
      step();
      expect_now(S_EN, 32'd0, "zero_epochs_hold.enable");
      do_start(5, 0);
      expect_all(0, 0, 0, 0, 1, 0, "zero_len");

`ifdef CODE_SEQ_WDOG_EN
      do_start(1, 2);
      expect_now(S_WD, 32'd0, "wdog_start");
      repeat (15) step();
      expect_now(S_CNT, 32'd15, "wdog_pre.count");
      expect_now(S_WD, 32'd0, "wdog_pre.err");
      expect_now(S_EN, 32'd1, "wdog_pre.enable");
      step();
      expect_now(S_WD, 32'd1, "wdog_trip.err");
      expect_now(S_DONE, 32'd1, "wdog_trip.done");
      expect_now(S_EN, 32'd0, "wdog_trip.enable");
      do_start(1, 2);
      expect_now(S_WD, 32'd0, "wdog_clear");
      code_reset = 1'b1; step(); code_reset = 1'b0;
`else
      do_start(1, 2);
      repeat (20) step();
      expect_now(S_CNT, 32'd20, "nowdog.count");
      expect_now(S_WD, 32'd0, "nowdog.err");
      expect_now(S_EN, 32'd1, "nowdog.enable");
      code_reset = 1'b1; step(); code_reset = 1'b0;
      expect_now(S_DONE, 32'd1, "nowdog_done");
`endif

      step(); step();
      while (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: never compared (due cycle %0d)", q[0].name, q[0].cyc);
         void'(q.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/code_sequencer.md
Name: code_sequencer

Overview:
- Program sequencer that drives the training controller: owns the program memory of op codes and generates op, code_count and code_index.
- Consumes the controller's count-reset, code_reset and code_active strobes.
- Sits upstream of the controller in the training loop; it is the other end of the op/count/index handshake.
- Runs a loaded program for a requested number of epochs, then halts.

Parameters:
- OP_SIZE, 4, op code width; matches controller op_size.
- ADDR_W, 4, program address width; depth 2**ADDR_W lines.
- WDOG_LIMIT, 1024, watchdog code_count limit; used only when CODE_SEQ_WDOG_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a run from IDLE.
- epoch_count  in  32  epochs to run; sampled on start.
- prog_len  in  ADDR_W+1  number of valid program lines; sampled on start.
- prog_we  in  1  program write strobe; honoured only in IDLE/DONE.
- prog_addr  in  ADDR_W  program write address.
- prog_op  in  OP_SIZE  op code written.
- count_reset  in  1  from controller reset output; clear code_count.
- code_reset  in  1  from controller; end of epoch.
- code_active  in  1  from controller; advance to next line.
- op  out  OP_SIZE  current line op code.
- code_count  out  32  cycles spent in current line.
- code_index  out  32  current line index, zero-extended.
- enable  out  1  controller enable; high only in RUN.
- busy  out  1  high in RUN.
- done  out  1  high in DONE until next start.
- epochs_left  out  32  remaining epochs.
- wdog_err  out  1  watchdog flag; tied 0 without the macro.

Behaviour:
- Reset (async, immediate): state IDLE; op=0, code_count=0, code_index=0, enable=0, busy=0, done=0, epochs_left=0, wdog_err=0. Program memory contents are not reset.
- State machine: IDLE, RUN, DONE.
- Program writes: accepted in IDLE and DONE only, 1-cycle write. prog_we in RUN is ignored.
- Start in IDLE or DONE:
  - If epoch_count==0 or prog_len==0: go to DONE next cycle, done=1, epochs_left=0.
  - Otherwise: go to RUN; epochs_left=epoch_count, code_index=0, code_count=0, op=mem[0], done=0, all registered on the same edge.
- Start while in RUN is ignored.
- op and code_index are always registered together: whenever the index changes, op is loaded with mem[next_index] on the same edge, so they never mismatch.
- Controller inputs are evaluated only in RUN and ignored in IDLE/DONE. Per-cycle priority in RUN, highest first:
  1. code_reset: code_index=0, code_count=0, op=mem[0], epochs_left-=1. If epochs_left was 1: go to DONE (enable=0, done=1, op=0).
  2. code_active: code_count=0. If code_index==prog_len-1, wrap code_index to 0 (no epoch decrement); else code_index+=1.
  3. count_reset: code_count=0; index unchanged.
  4. None of the above: code_count+=1, saturating at 32'hFFFF_FFFF.
- NOP lines (op 0) cause the controller to assert code_active every cycle, so each NOP line occupies exactly 1 cycle.
- enable is registered and equals (state==RUN). Outputs respond to controller strobes with 1-cycle latency.
- Reset mid-run aborts immediately to IDLE; the program memory is preserved.

Optional Feature:
- Macro CODE_SEQ_WDOG_EN.
- Defined: if code_count reaches WDOG_LIMIT-1 in RUN with no strobe that cycle, the next edge sets wdog_err=1 and enters DONE (done=1, enable=0). wdog_err clears on start or rst.
- Undefined: no watchdog logic is built; wdog_err is constant 0 and code_count saturates.

Test Plan:
- Load mem[0]=1, mem[1]=2, prog_len=2, epoch_count=3, start; hold all controller strobes low 5 cycles -> enable=1, op=1, code_index=0, code_count counts 0..5.
- With the same program, pulse code_active -> next cycle code_index=1, op=2, code_count=0. Pulse code_reset -> code_index=0, op=1, epochs_left=2.
- Three code_reset pulses -> epochs_left 3->2->1, then DONE: done=1, enable=0, op=0. Further strobes cause no change.
- Same-cycle code_reset and code_active -> code_reset wins: index=0, epochs_left decrements once. code_active at index=prog_len-1 -> wrap to 0, epochs_left unchanged.
- start with epoch_count=0 -> DONE after 1 cycle, enable never asserts. prog_we during RUN with addr 0, op 7 -> after the run, mem[0] still reads 1.
- Assert rst mid-RUN -> outputs zero immediately (async). Restart with no reload -> op=1, showing memory is retained. With CODE_SEQ_WDOG_EN and WDOG_LIMIT=16, no strobes -> wdog_err=1 after 16 RUN cycles.
